// File: rtl/gated_bcd_counter.sv
// gated_bcd_counter: counts synchronised sig_in rising edges while gate is open, as a saturating BCD value.
// Latch captures the pre-update count and overflow; clr zeroes the running count.
module gated_bcd_counter #(
    parameter int DIGITS      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  sig_in,
    input  logic                  gate,
    input  logic                  latch,
    input  logic                  clr,
    output logic [4*DIGITS-1:0]   freq_bcd,
    output logic                  ovf,
    output logic                  valid,
    output logic                  seq_err
);
    logic [SYNC_STAGES-1:0][3:0] r_sync;
    logic [3:0]                  r_dly;
    logic [4*DIGITS-1:0]         r_cnt;
    logic                        r_ovf_int;
    logic [3:0]                  w_in, w_s;
    logic                        w_sig_rise, w_lat_rise, w_clr_rise, w_cnt_en;
    logic [4*DIGITS-1:0]         w_inc;
    logic [DIGITS:0]             w_carry;

    assign w_in       = {clr, latch, gate, sig_in};
    assign w_s        = r_sync[SYNC_STAGES-1];
    assign w_sig_rise = w_s[0] & ~r_dly[0];
    assign w_lat_rise = w_s[2] & ~r_dly[2];
    assign w_clr_rise = w_s[3] & ~r_dly[3];
    assign w_cnt_en   = w_s[1] & w_sig_rise;
    assign w_carry[0] = 1'b1;

    // Carry ripples through all digits in one cycle; w_carry[DIGITS] means the count is all nines.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign w_carry[i+1]  = w_carry[i] & (r_cnt[4*i +: 4] == 4'd9);
        assign w_inc[4*i +: 4] = !w_carry[i] ? r_cnt[4*i +: 4] :
                                 (r_cnt[4*i +: 4] == 4'd9) ? 4'd0 : r_cnt[4*i +: 4] + 4'd1;
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_sync    <= '0;
            r_dly     <= '0;
            r_cnt     <= '0;
            r_ovf_int <= 1'b0;
            freq_bcd  <= '0;
            ovf       <= 1'b0;
            valid     <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1)
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
            else
                r_sync <= w_in;
            r_dly   <= w_s;
            valid   <= w_lat_rise;
            seq_err <= w_lat_rise & w_s[1];
            if (w_lat_rise) begin
                freq_bcd <= r_cnt;
                ovf      <= r_ovf_int;
            end
            if (w_clr_rise) begin
                r_cnt     <= '0;
                r_ovf_int <= 1'b0;
            end else if (w_cnt_en) begin
                if (w_carry[DIGITS])
                    r_ovf_int <= 1'b1;
                else
                    r_cnt <= w_inc;
            end
        end
    end
endmodule

// File: tb/tb_gated_bcd_counter.sv
// tb_gated_bcd_counter: directed stimulus with a scoreboard of expected latch results per instance.
// A 6-digit instance covers the main behaviour; a 2-digit instance makes saturation reachable quickly.
module tb_gated_bcd_counter;
    typedef struct {
        logic [23:0] f;
        logic        o;
        logic        s;
    } exp_t;

    logic clk_in = 0, reset = 1;
    logic sig = 0, gate = 0, latch = 0, clr = 0, sel = 0;
    logic [23:0] a_freq;
    logic [7:0]  b_freq;
    logic a_ovf, a_valid, a_seq, b_ovf, b_valid, b_seq;
    exp_t q_a[$], q_b[$];
    exp_t ea, eb;
    int checks = 0, errors = 0;

    always #5 clk_in = ~clk_in;

    gated_bcd_counter #(.DIGITS(6), .SYNC_STAGES(2)) dut_a (
        .clk_in(clk_in), .reset(reset),
        .sig_in(sel ? 1'b0 : sig), .gate(sel ? 1'b0 : gate),
        .latch(sel ? 1'b0 : latch), .clr(sel ? 1'b0 : clr),
        .freq_bcd(a_freq), .ovf(a_ovf), .valid(a_valid), .seq_err(a_seq)
    );

    gated_bcd_counter #(.DIGITS(2), .SYNC_STAGES(2)) dut_b (
        .clk_in(clk_in), .reset(reset),
        .sig_in(sel ? sig : 1'b0), .gate(sel ? gate : 1'b0),
        .latch(sel ? latch : 1'b0), .clr(sel ? clr : 1'b0),
        .freq_bcd(b_freq), .ovf(b_ovf), .valid(b_valid), .seq_err(b_seq)
    );

    function automatic bit bad_bcd(input logic [23:0] v);
        bad_bcd = 0;
        for (int i = 0; i < 6; i++)
            if (v[4*i +: 4] > 4'd9) bad_bcd = 1;
    endfunction

    always @(negedge clk_in) begin
        if (!reset) begin
            if (a_valid) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected_valid freq=%h", a_freq);
                end else begin
                    ea = q_a.pop_front();
                    if (a_freq !== ea.f || a_ovf !== ea.o || a_seq !== ea.s) begin
                        errors++;
                        $display("FAIL a_latch got freq=%h ovf=%b seq_err=%b want freq=%h ovf=%b seq_err=%b",
                                 a_freq, a_ovf, a_seq, ea.f, ea.o, ea.s);
                    end
                end
                checks++;
                if (bad_bcd(a_freq)) begin
                    errors++;
                    $display("FAIL a_nibble_range got %h want all nibbles <= 9", a_freq);
                end
            end else if (a_seq) begin
                checks++;
                errors++;
                $display("FAIL a_seq_err_without_valid got 1 want 0");
            end
            if (b_valid) begin
                checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_valid freq=%h", b_freq);
                end else begin
                    eb = q_b.pop_front();
                    if ({16'h0, b_freq} !== eb.f || b_ovf !== eb.o || b_seq !== eb.s) begin
                        errors++;
                        $display("FAIL b_latch got freq=%h ovf=%b seq_err=%b want freq=%h ovf=%b seq_err=%b",
                                 b_freq, b_ovf, b_seq, eb.f[7:0], eb.o, eb.s);
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #2;
        end
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            sig = 1; cyc(2);
            sig = 0; cyc(2);
        end
    endtask

    task automatic expect_latch(input logic [23:0] f, input logic o, input logic s);
        exp_t e;
        e.f = f; e.o = o; e.s = s;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
    endtask

    task automatic do_latch(input logic [23:0] f, input logic o, input logic s);
        expect_latch(f, o, s);
        latch = 1; cyc(2);
        latch = 0; cyc(2);
    endtask

    task automatic do_clr();
        clr = 1; cyc(2);
        clr = 0; cyc(2);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (a_freq !== 24'h0 || a_ovf !== 1'b0 || a_valid !== 1'b0 || a_seq !== 1'b0) begin
            errors++;
            $display("FAIL %s got freq=%h ovf=%b valid=%b seq_err=%b want all zero",
                     name, a_freq, a_ovf, a_valid, a_seq);
        end
    endtask

    initial begin
        cyc(3);
        check_idle("reset_state");
        reset = 0;
        cyc(2);

        // normal window
        do_clr();
        gate = 1; cyc(4);
        pulse(1234);
        gate = 0; cyc(4);
        do_latch(24'h001234, 0, 0);

        // reset mid-window discards the partial count
        do_clr();
        gate = 1; cyc(4);
        pulse(37);
        reset = 1; #1;
        check_idle("reset_async");
        cyc(1);
        reset = 0; cyc(4);
        pulse(5);
        gate = 0; cyc(4);
        do_latch(24'h000005, 0, 0);

        // gate closed, then latch while gate open
        do_clr();
        pulse(500);
        do_latch(24'h000000, 0, 0);
        gate = 1; cyc(4);
        do_latch(24'h000000, 0, 1);
        gate = 0; cyc(4);

        // carry chain
        do_clr();
        gate = 1; cyc(4);
        pulse(99);
        gate = 0; cyc(4);
        do_latch(24'h000099, 0, 0);
        gate = 1; cyc(4);
        pulse(1);
        gate = 0; cyc(4);
        do_latch(24'h000100, 0, 0);
        gate = 1; cyc(4);
        pulse(9899);
        gate = 0; cyc(4);
        do_latch(24'h009999, 0, 0);
        gate = 1; cyc(4);
        pulse(1);
        gate = 0; cyc(4);
        do_latch(24'h010000, 0, 0);

        // latch and signal edge in the same cycle at count 41
        do_clr();
        gate = 1; cyc(4);
        pulse(41);
        expect_latch(24'h000041, 0, 1);
        sig = 1; latch = 1; cyc(2);
        sig = 0; latch = 0; cyc(2);
        gate = 0; cyc(4);
        do_latch(24'h000042, 0, 0);

        // clear and signal edge in the same cycle
        gate = 1; cyc(4);
        sig = 1; clr = 1; cyc(2);
        sig = 0; clr = 0; cyc(2);
        gate = 0; cyc(4);
        do_latch(24'h000000, 0, 0);

        // latch and clear in the same cycle
        gate = 1; cyc(4);
        pulse(3);
        gate = 0; cyc(4);
        expect_latch(24'h000003, 0, 0);
        latch = 1; clr = 1; cyc(2);
        latch = 0; clr = 0; cyc(2);
        do_latch(24'h000000, 0, 0);

        // overflow on the 2-digit instance
        sel = 1; cyc(4);
        do_clr();
        gate = 1; cyc(4);
        pulse(102);
        gate = 0; cyc(4);
        do_latch(24'h000099, 1, 0);
        do_clr();
        gate = 1; cyc(4);
        pulse(3);
        gate = 0; cyc(4);
        do_latch(24'h000003, 0, 0);

        for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) cyc(1);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain got pending a=%0d b=%0d want 0 0", q_a.size(), q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gated_bcd_counter.md
Name: gated_bcd_counter

Overview:
- Consumer end of the frequency-meter timing control interface.
- Counts rising edges of the signal under test while the gate window is open.
- On the latch strobe, transfers the running BCD count and overflow flag to stable output registers for display.
- On the clear strobe, zeroes the running count ready for the next window.
- All logic runs on the single system clock; sig_in, gate, latch and clr are treated as asynchronous and synchronised internally.

Parameters:
- DIGITS, 6: number of BCD digits; count range 0 to 10^DIGITS-1.
- SYNC_STAGES, 2: synchroniser flops per asynchronous input, minimum 2.

Ports:
- clk_in, input, 1: system clock; all registers are on its rising edge.
- reset, input, 1: asynchronous, active-high; clears every register.
- sig_in, input, 1: signal under test.
- gate, input, 1: count-enable window from the control block, level sensitive.
- latch, input, 1: capture strobe from the control block; acts on its rising edge.
- clr, input, 1: counter-clear strobe from the control block; acts on its rising edge.
- freq_bcd, output, 4*DIGITS: latched count; digit 0 is in [3:0], the most significant digit is in the top nibble.
- ovf, output, 1: latched overflow flag for the captured window.
- valid, output, 1: one-cycle pulse in the cycle freq_bcd and ovf update.
- seq_err, output, 1: one-cycle pulse when a latch edge is seen while the synchronised gate is high.

Behaviour:
- Reset (asynchronous, active-high):
  - All synchronisers, edge registers, running count, sticky overflow, freq_bcd, ovf, valid and seq_err go to 0 immediately.
  - Reset asserted mid-window discards the partial count.
  - After release, counting resumes on the first qualified edge.
- Synchronisation:
  - Each of sig_in, gate, latch and clr passes through SYNC_STAGES flops, then one delay flop for edge detection.
  - sig_rise = sig_s & ~sig_d.
  - lat_rise and clr_rise are formed the same way.
- Count qualification:
  - cnt_en = gate_s & sig_rise.
  - Latency from a sig_in rising edge to the running-count update is SYNC_STAGES+1 cycles.
  - sig_in high and low phases must each be at least 2 clk_in periods. Narrower pulses may be missed; this is not flagged.
- BCD increment:
  - Digit 0 increments on cnt_en.
  - A digit at 9 wraps to 0 and carries into the next digit; the carry ripples combinationally within one cycle.
  - Values above 9 are never produced.
- Overflow:
  - An increment at all-9s holds the count at all-9s (saturates) and sets sticky ovf_int.
  - Further edges leave the count at all-9s.
- Clear:
  - On clr_rise, running count = 0 and ovf_int = 0 on the next edge.
  - clr_rise takes priority over cnt_en in the same cycle, so that edge is lost.
- Latch:
  - On lat_rise, freq_bcd <= running count and ovf <= ovf_int, both taken as the value before any same-cycle increment or clear.
  - valid = 1 for exactly that cycle.
  - freq_bcd and ovf hold between latches.
- Simultaneous events:
  - lat_rise + cnt_en: latch captures the pre-increment value; the increment still applies to the running count.
  - lat_rise + clr_rise: latch captures the pre-clear value; the clear applies.
  - clr_rise + cnt_en: the result is 0.
- seq_err:
  - Pulses for one cycle on lat_rise while gate_s = 1.
  - The latch is still performed.
- Gate:
  - Level only; opening and closing the window never modifies the count.
  - A gate reopened without a clr accumulates onto the existing count.
- No internal FSM state survives other than the registers listed; the block is stateless across windows apart from count and ovf_int.

Test Plan:
- Reset mid-window: gate high, 37 pulses, reset asserted for 1 cycle → freq_bcd=0, ovf=0, valid=0 immediately. Then 5 pulses, latch → freq_bcd=24'h000005.
- Normal window: clr, gate high, 1234 pulses, gate low, latch → freq_bcd=24'h001234, ovf=0, valid high exactly 1 cycle, seq_err=0.
- Gate closed: 500 pulses with gate low, then latch → freq_bcd=24'h000000. A subsequent latch with gate high → seq_err pulses 1 cycle.
- Carry chain: preload via 99 pulses then 1 more → 24'h000100; from 9999 plus 1 → 24'h010000; check no nibble ever exceeds 9.
- Overflow: 1,000,001 pulses in a window, latch → freq_bcd=24'h999999, ovf=1. Then clr, 3 pulses, latch → 24'h000003, ovf=0.
- Collisions:
  - Arrange lat_rise and sig_rise in the same cycle at count 41 → freq_bcd=24'h000041 and running count 42.
  - clr_rise with sig_rise in the same cycle → running count 0.
